// File: rtl/shot_resolver.sv
// shot_resolver: ship/shot boards with synchronized PLACE/FIRE presses resolved to MISS/HIT/REPEAT/REJECT.
// Optional shot budget with LOST outcome when SHOT_LIMIT_EN is defined.
module shot_resolver #(
  parameter int ROWS        = 5,
  parameter int COLS        = 7,
  parameter int MAX_SHIPS   = 9,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SHOTS   = 20,
  localparam int CW         = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          place,
  input  logic          fire,
  input  logic [2:0]    row,
  input  logic [2:0]    col,
  output logic [1:0]    result,
  output logic          result_valid,
  output logic [1:0]    state,
  output logic          locked,
  output logic [CW-1:0] ships,
  output logic [CW-1:0] hits,
  output logic [CW-1:0] shots,
  output logic          game_over
);

  localparam logic [1:0] SETUP = 2'b00;
  localparam logic [1:0] PLAY  = 2'b01;
  localparam logic [1:0] WON   = 2'b10;
  localparam logic [1:0] LOST  = 2'b11;

  localparam logic [1:0] RES_MISS   = 2'b00;
  localparam logic [1:0] RES_HIT    = 2'b01;
  localparam logic [1:0] RES_REPEAT = 2'b10;
  localparam logic [1:0] RES_REJECT = 2'b11;

  localparam int            NCELL    = ROWS*COLS;
  localparam int            IW       = $clog2(NCELL);
  localparam logic [2:0]    ROW_MAX  = 3'(ROWS);
  localparam logic [2:0]    COL_MAX  = 3'(COLS);
  localparam logic [CW-1:0] SHIP_CAP = CW'(MAX_SHIPS);
`ifdef SHOT_LIMIT_EN
  localparam logic [CW-1:0] SHOT_CAP = CW'(MAX_SHOTS);
`endif

  if (SYNC_STAGES < 2 || MAX_SHIPS > NCELL || MAX_SHOTS < 1) begin : g_param_check
    $error("shot_resolver: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] place_sync, fire_sync;
  logic                   place_prev, fire_prev;
  logic                   place_edge, fire_edge;
  logic                   place_evt, fire_evt;
  logic [2:0]             row_q, col_q;

  assign place_edge = place_sync[SYNC_STAGES-1] & ~place_prev;
  assign fire_edge  = fire_sync[SYNC_STAGES-1] & ~fire_prev;

  // Synchronizers reset to ones so a button still held across reset never looks like a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      place_sync <= '1;
      fire_sync  <= '1;
      place_prev <= 1'b1;
      fire_prev  <= 1'b1;
      place_evt  <= 1'b0;
      fire_evt   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      place_sync <= {place_sync[SYNC_STAGES-2:0], place};
      fire_sync  <= {fire_sync[SYNC_STAGES-2:0], fire};
      place_prev <= place_sync[SYNC_STAGES-1];
      fire_prev  <= fire_sync[SYNC_STAGES-1];
      place_evt  <= place_edge;
      fire_evt   <= fire_edge;
      if (place_edge || fire_edge) begin
        row_q <= row;
        col_q <= col;
      end
    end
  end

  logic [NCELL-1:0] ship_board, shot_board;
  logic [IW-1:0]    idx;
  logic             act, coord_ok, ship_here, shot_here, win;
  logic [CW-1:0]    hits_inc, shots_inc;

  assign idx       = IW'((int'(row_q) - 1) * COLS + int'(col_q) - 1);
  assign coord_ok  = (row_q != 3'd0) && (row_q <= ROW_MAX) && (col_q != 3'd0) && (col_q <= COL_MAX);
  assign act       = (place_evt | fire_evt) & ~state[1];
  assign ship_here = ship_board[idx];
  assign shot_here = shot_board[idx];
  assign hits_inc  = hits + CW'(1);
  assign shots_inc = shots + CW'(1);
  assign win       = ship_here && (hits_inc == ships);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SETUP;
      ship_board   <= '0;
      shot_board   <= '0;
      ships        <= '0;
      hits         <= '0;
      shots        <= '0;
      result       <= RES_MISS;
      result_valid <= 1'b0;
    end else if (!enable) begin
      state        <= SETUP;
      ship_board   <= '0;
      shot_board   <= '0;
      ships        <= '0;
      hits         <= '0;
      shots        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= act;
      if (act) begin
        if (!coord_ok) begin
          result <= RES_REJECT;
        end else if (fire_evt) begin
          // FIRE wins over a coincident PLACE; the PLACE is simply dropped.
          if (state == SETUP && ships == '0) begin
            result <= RES_REJECT;
          end else begin
            state <= PLAY;
            if (shot_here) begin
              result <= RES_REPEAT;
            end else begin
              shot_board[idx] <= 1'b1;
              shots           <= shots_inc;
              if (ship_here) begin
                result <= RES_HIT;
                hits   <= hits_inc;
              end else begin
                result <= RES_MISS;
              end
              if (win) begin
                state <= WON;
              end
`ifdef SHOT_LIMIT_EN
              else if (shots_inc == SHOT_CAP) begin
                state <= LOST;
              end
`endif
            end
          end
        end else if (state == PLAY) begin
          result <= RES_REJECT;
        end else if (ship_here) begin
          ship_board[idx] <= 1'b0;
          ships           <= ships - CW'(1);
          result          <= RES_MISS;
        end else if (ships == SHIP_CAP) begin
          result <= RES_REJECT;
        end else begin
          ship_board[idx] <= 1'b1;
          ships           <= ships + CW'(1);
          result          <= RES_HIT;
        end
      end
    end
  end

  assign locked    = (state != SETUP);
  assign game_over = state[1];

endmodule

// File: tb/tb_shot_resolver.sv
// Bench for shot_resolver: board-level game model checked every cycle plus literal per-press expectations.
`timescale 1ns/1ps
module tb_shot_resolver;
  localparam int ROWS  = 5;
  localparam int COLS  = 7;
  localparam int MAXSH = 9;
  localparam int SYNC  = 2;
`ifdef SHOT_LIMIT_EN
  localparam int MSHOTS = 3;
`else
  localparam int MSHOTS = 20;
`endif
  localparam int CW = $clog2(ROWS*COLS+1);

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b1, place = 1'b0, fire = 1'b0;
  logic [2:0]    row = 3'd0, col = 3'd0;
  logic [1:0]    result, state;
  logic          result_valid, locked, game_over;
  logic [CW-1:0] ships, hits, shots;

  shot_resolver #(.ROWS(ROWS), .COLS(COLS), .MAX_SHIPS(MAXSH), .SYNC_STAGES(SYNC), .MAX_SHOTS(MSHOTS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .place(place), .fire(fire), .row(row), .col(col),
    .result(result), .result_valid(result_valid), .state(state), .locked(locked),
    .ships(ships), .hits(hits), .shots(shots), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0, passed = 0, total = 0, nstrobe = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Game model: kind 0 place, 1 fire, 2 place+fire, 3 enable-low clear.
  typedef struct {int due; int kind; int r; int c;} ev_t;
  ev_t evq[$];
  bit  m_ship[1:ROWS][1:COLS];
  bit  m_shot[1:ROWS][1:COLS];
  int  m_ships = 0, m_hits = 0, m_shots = 0, m_state = 0, m_res = 0;

  task automatic mclear();
    for (int r = 1; r <= ROWS; r++)
      for (int c = 1; c <= COLS; c++) begin
        m_ship[r][c] = 1'b0;
        m_shot[r][c] = 1'b0;
      end
    m_ships = 0; m_hits = 0; m_shots = 0; m_state = 0;
  endtask

  task automatic mapply(input ev_t ev, output bit strobe);
    strobe = 1'b0;
    if (ev.kind == 3) begin
      mclear();
    end else if (m_state < 2) begin
      strobe = 1'b1;
      if (ev.r < 1 || ev.r > ROWS || ev.c < 1 || ev.c > COLS) m_res = 3;
      else if (ev.kind != 0) begin
        if (m_state == 0 && m_ships == 0) m_res = 3;
        else begin
          m_state = 1;
          if (m_shot[ev.r][ev.c]) m_res = 2;
          else begin
            m_shot[ev.r][ev.c] = 1'b1;
            m_shots++;
            if (m_ship[ev.r][ev.c]) begin m_hits++; m_res = 1; end
            else m_res = 0;
            if (m_hits == m_ships) m_state = 2;
`ifdef SHOT_LIMIT_EN
            else if (m_shots == MSHOTS) m_state = 3;
`endif
          end
        end
      end else if (m_state == 1) m_res = 3;
      else if (m_ship[ev.r][ev.c]) begin m_ship[ev.r][ev.c] = 1'b0; m_ships--; m_res = 0; end
      else if (m_ships == MAXSH) m_res = 3;
      else begin m_ship[ev.r][ev.c] = 1'b1; m_ships++; m_res = 1; end
    end
  endtask

  always @(negedge clk) begin
    bit exp_vld;
    exp_vld = 1'b0;
    if (rst) begin
      mclear();
      m_res = 0;
      evq.delete();
    end else if (evq.size() > 0 && evq[0].due == cyc) begin
      mapply(evq.pop_front(), exp_vld);
    end
    if (!rst && result_valid) nstrobe++;
    chk("result_valid", result_valid, exp_vld);
    chk("result", result, m_res);
    chk("state", state, m_state);
    chk("ships", ships, m_ships);
    chk("hits", hits, m_hits);
    chk("shots", shots, m_shots);
    chk("locked", locked, m_state != 0);
    chk("game_over", game_over, m_state >= 2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input bit p, input bit f, input int r, input int c,
                       input int exp_n, input int exp_res, input string name);
    int n0;
    n0 = nstrobe;
    row = 3'(r); col = 3'(c); place = p; fire = f;
    evq.push_back('{cyc + 1 + SYNC + 1, (p && f) ? 2 : (f ? 1 : 0), r, c});
    repeat (5) tick();
    place = 1'b0; fire = 1'b0;
    repeat (6) tick();
    chk({name, "_strobes"}, nstrobe - n0, exp_n);
    chk({name, "_result"}, result, exp_res);
  endtask

  task automatic power_cycle();
    enable = 1'b0;
    evq.push_back('{cyc + 1, 3, 0, 0});
    tick();
    enable = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_ships", ships, 0);
    rst = 1'b0;
    repeat (3) tick();

    press(0, 1, 2, 2, 1, 3, "fire_no_ships");
    chk("fire_no_ships_state", state, 0);
    press(1, 0, 6, 1, 1, 3, "place_row6");
    press(1, 0, 1, 0, 1, 3, "place_col0");
    press(1, 0, 0, 3, 1, 3, "place_row0");
    chk("bad_coord_ships", ships, 0);

    press(1, 0, 1, 1, 1, 1, "t1_a");
    press(1, 0, 5, 7, 1, 1, "t1_b");
    press(1, 0, 1, 1, 1, 0, "t1_c");
    chk("t1_ships", ships, 1);
    chk("t1_state", state, 0);

    press(1, 0, 5, 7, 1, 0, "t2_remove");
    press(1, 0, 2, 3, 1, 1, "t2_ship_a");
    press(1, 0, 2, 4, 1, 1, "t2_ship_b");
    press(0, 1, 1, 1, 1, 0, "t2_miss");
    chk("t2_locked", locked, 1);
    press(0, 1, 2, 3, 1, 1, "t2_hit");
    press(0, 1, 2, 3, 1, 2, "t2_repeat");
    press(0, 1, 2, 4, 1, 1, "t2_win");
    chk("t2_shots", shots, 3);
    chk("t2_hits", hits, 2);
    chk("t2_state", state, 2);
    chk("t2_game_over", game_over, 1);
    press(0, 1, 3, 3, 0, 1, "won_fire_ignored");
    press(1, 0, 3, 3, 0, 1, "won_place_ignored");

    power_cycle();
    chk("clear_state", state, 0);
    chk("clear_shots", shots, 0);

    for (int i = 0; i < MAXSH; i++) press(1, 0, 1 + i / COLS, 1 + i % COLS, 1, 1, "fill");
    press(1, 0, 3, 3, 1, 3, "place_full");
    chk("full_ships", ships, 9);
    press(0, 1, 1, 1, 1, 1, "t4_hit");
    press(1, 1, 3, 3, 1, 0, "both_fire_wins");
    chk("both_ships", ships, 9);
    chk("both_shots", shots, 2);
    press(1, 0, 4, 4, 1, 3, "play_place");

    power_cycle();
    chk("t5_state", state, 0);
    chk("t5_hits", hits, 0);
    chk("t5_ships", ships, 0);

    n0 = nstrobe;
    row = 3'd3; col = 3'd3; place = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    place = 1'b0;
    repeat (8) tick();
    chk("rst_mid_press_strobes", nstrobe - n0, 0);
    press(1, 0, 3, 3, 1, 1, "after_rst");

`ifdef SHOT_LIMIT_EN
    power_cycle();
    press(1, 0, 1, 1, 1, 1, "t6_ship");
    press(0, 1, 2, 1, 1, 0, "t6_miss1");
    press(0, 1, 2, 2, 1, 0, "t6_miss2");
    press(0, 1, 2, 2, 1, 2, "t6_repeat");
    press(0, 1, 2, 3, 1, 0, "t6_miss3");
    chk("t6_state", state, 3);
    chk("t6_game_over", game_over, 1);
    press(0, 1, 3, 3, 0, 0, "t6_lost_ignored");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
